aurora_tx_arbiter: RTL and testbench

Frame-atomic round-robin arbiter that merges N AXI-Stream frame sources (per-channel TX FIFOs) onto the single TX stream feeding the Aurora TX guard and Aurora IP. It holds a grant for a whole frame, from the first beat through the beat carrying tlast. It issues new grants only while the link is up, and lets software mask individual sources.

---
 rtl/aurora_tx_arbiter.sv | 106 ++++++++++
 tb/tb_aurora_tx_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_tx_arbiter.sv
// Frame-atomic round-robin arbiter merging N AXI-Stream sources onto one Aurora TX stream.
// A grant is held from the first beat through tlast; new grants are issued only while channel_up=1.
module aurora_tx_arbiter #(
  parameter int unsigned N      = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned KEEP_W = DATA_W / 8,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  rst,
  input  logic                  clk,
  input  logic                  channel_up,
  input  logic [N-1:0]          port_en,
  input  logic [N*DATA_W-1:0]   i_tdata,
  input  logic [N*KEEP_W-1:0]   i_tkeep,
  input  logic [N-1:0]          i_tvalid,
  input  logic [N-1:0]          i_tlast,
  output logic [N-1:0]          i_tready,
  output logic [DATA_W-1:0]     o_tdata,
  output logic [KEEP_W-1:0]     o_tkeep,
  output logic                  o_tvalid,
  output logic                  o_tlast,
  input  logic                  o_tready,
  output logic                  grant_vld,
  output logic [IDX_W-1:0]      grant_idx
);

  typedef enum logic {IDLE, XFER} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] pick;
  logic             found;
  logic [N-1:0]     req;

  assign req = i_tvalid & port_en;

  // Round-robin search starting just after the most recently completed source.
  always_comb begin : rr_pick
    int unsigned idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = (32'(last_q) + off) % N;
      if (!found && req[IDX_W'(idx)]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= IDX_W'(N - 1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (channel_up && found) begin
          sel_d   = pick;
          state_d = XFER;
        end
      end
      XFER: begin
        // Grant is locked: only the tlast handshake releases it.
        if (o_tvalid && o_tready && o_tlast) begin
          state_d = IDLE;
          last_d  = sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Combinational datapath steered by the registered selection.
  always_comb begin : out_mux
    o_tdata  = i_tdata[0 +: DATA_W];
    o_tkeep  = i_tkeep[0 +: KEEP_W];
    o_tlast  = i_tlast[0];
    o_tvalid = 1'b0;
    i_tready = '0;
    if (state_q == XFER) begin
      o_tdata         = i_tdata[32'(sel_q) * DATA_W +: DATA_W];
      o_tkeep         = i_tkeep[32'(sel_q) * KEEP_W +: KEEP_W];
      o_tlast         = i_tlast[sel_q];
      o_tvalid        = i_tvalid[sel_q];
      i_tready[sel_q] = o_tready;
    end
  end

  assign grant_vld = (state_q == XFER);
  assign grant_idx = sel_q;

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Randomized bench for aurora_tx_arbiter: frame-level reference model checked every cycle,
// plus directed scenarios pinned by literal expectations.
module tb_aurora_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int KW = 1;
  localparam int IW = 2;

  logic          rst, clk, channel_up, o_tready;
  logic [N-1:0]  port_en, i_tvalid, i_tlast, i_tready;
  logic [N*DW-1:0] i_tdata;
  logic [N*KW-1:0] i_tkeep;
  logic [DW-1:0] o_tdata;
  logic [KW-1:0] o_tkeep;
  logic          o_tvalid, o_tlast, grant_vld;
  logic [IW-1:0] grant_idx;

  aurora_tx_arbiter #(.N(N), .DATA_W(DW), .KEEP_W(KW)) dut (
    .rst(rst), .clk(clk), .channel_up(channel_up), .port_en(port_en),
    .i_tdata(i_tdata), .i_tkeep(i_tkeep), .i_tvalid(i_tvalid), .i_tlast(i_tlast),
    .i_tready(i_tready), .o_tdata(o_tdata), .o_tkeep(o_tkeep), .o_tvalid(o_tvalid),
    .o_tlast(o_tlast), .o_tready(o_tready), .grant_vld(grant_vld), .grant_idx(grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which source owns the stream (-1 = none) and who finished last.
  int cur = -1, prev = N - 1, sel = 0;
  int cur_n = -1, prev_n = N - 1, sel_n = 0;
  logic [N-1:0] hs = '0;
  logic gv_prev = 1'b0;
  int dut_grants[$];

  always @(negedge clk) begin : compare
    logic [N-1:0] exp_rdy;
    logic exp_v;
    int k;
    exp_rdy = '0;
    exp_v   = 1'b0;
    if (cur >= 0) begin
      exp_v        = i_tvalid[cur];
      exp_rdy[cur] = o_tready;
    end
    chk("grant_vld", 64'(grant_vld), 64'(cur >= 0));
    chk("grant_idx", 64'(grant_idx), 64'(sel));
    chk("o_tvalid", 64'(o_tvalid), 64'(exp_v));
    chk("i_tready", 64'(i_tready), 64'(exp_rdy));
    if (exp_v) begin
      chk("o_tdata", 64'(o_tdata), 64'(i_tdata[cur*DW +: DW]));
      chk("o_tkeep", 64'(o_tkeep), 64'(i_tkeep[cur*KW +: KW]));
      chk("o_tlast", 64'(o_tlast), 64'(i_tlast[cur]));
    end
    hs = exp_rdy & i_tvalid;
    if (grant_vld === 1'b1 && !gv_prev) dut_grants.push_back(int'(grant_idx));
    gv_prev = (grant_vld === 1'b1);
    cur_n  = cur;
    prev_n = prev;
    sel_n  = sel;
    if (cur < 0) begin
      if (channel_up && ((i_tvalid & port_en) != '0)) begin
        for (int o = 1; o <= N; o++) begin
          k = (prev + o) % N;
          if (i_tvalid[k] && port_en[k]) begin
            cur_n = k;
            sel_n = k;
            break;
          end
        end
      end
    end else if (exp_v && o_tready && i_tlast[cur]) begin
      cur_n  = -1;
      prev_n = cur;
    end
  end

  always @(posedge clk or posedge rst) begin : model_step
    if (rst) begin
      cur = -1; prev = N - 1; sel = 0;
    end else begin
      cur = cur_n; prev = prev_n; sel = sel_n;
    end
  end

  // Source emulation: each port presents frames of flen beats (0 = random 1..4).
  bit           act[N];
  bit           gen[N];
  int           len[N], beat[N], flen[N];
  logic [DW-1:0] d[N];
  logic [KW-1:0] kp[N];
  int           rate = 100;
  int           stall_pct = 0;

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (hs[k]) begin
        if (beat[k] == len[k] - 1) act[k] = 1'b0;
        else begin
          beat[k]++;
          d[k]  = DW'($urandom);
          kp[k] = KW'($urandom);
        end
      end
      if (!act[k] && gen[k] && ($urandom_range(99) < rate)) begin
        act[k]  = 1'b1;
        len[k]  = (flen[k] != 0) ? flen[k] : int'($urandom_range(4, 1));
        beat[k] = 0;
        d[k]    = DW'($urandom);
        kp[k]   = KW'($urandom);
      end
      i_tvalid[k] = act[k] && !(beat[k] > 0 && ($urandom_range(99) < stall_pct));
      i_tdata[k*DW +: DW] = d[k];
      i_tkeep[k*KW +: KW] = kp[k];
      i_tlast[k] = act[k] && (beat[k] == len[k] - 1);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic set_gen(input logic [N-1:0] g, input int fl);
    for (int k = 0; k < N; k++) begin
      gen[k]  = g[k];
      flen[k] = fl;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  task automatic drain();
    set_gen('0, 0);
    port_en    = '1;
    channel_up = 1'b1;
    o_tready   = 1'b1;
    stall_pct  = 0;
    rate       = 100;
    repeat (40) cyc();
  endtask

  function automatic int grant_at(input int i);
    return (i < dut_grants.size()) ? dut_grants[i] : -1;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int cnt;
    int n0;
    bit found;
    logic [3:0] pat;
    rst = 1'b1; channel_up = 1'b1; o_tready = 1'b1; port_en = '1;
    i_tvalid = '0; i_tlast = '0; i_tdata = '0; i_tkeep = '0;
    for (int k = 0; k < N; k++) begin
      act[k] = 0; gen[k] = 0; len[k] = 1; beat[k] = 0; flen[k] = 0; d[k] = '0; kp[k] = '0;
    end
    repeat (2) cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_grant_vld", 64'(grant_vld), 64'd0);
    chk("rst_grant_idx", 64'(grant_idx), 64'd0);
    chk("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    chk("rst_i_tready", 64'(i_tready), 64'd0);

    // Port 2 alone, 3-beat frame.
    dut_grants.delete();
    set_gen(4'b0100, 3);
    cyc();
    set_gen('0, 3);
    @(negedge clk);
    chk("s1_pre_grant", 64'(grant_vld), 64'd0);
    cyc();
    @(negedge clk);
    chk("s1_grant_vld", 64'(grant_vld), 64'd1);
    chk("s1_grant_idx", 64'(grant_idx), 64'd2);
    cnt = int'(o_tvalid);
    repeat (5) begin
      cyc();
      @(negedge clk);
      cnt += int'(o_tvalid);
    end
    chk("s1_beats", 64'(cnt), 64'd3);
    chk("s1_ngrants", 64'(dut_grants.size()), 64'd1);

    // All ports, continuous 2-beat frames from reset.
    do_reset();
    dut_grants.delete();
    set_gen(4'b1111, 2);
    repeat (20) cyc();
    chk("s2_g0", 64'(grant_at(0)), 64'd0);
    chk("s2_g1", 64'(grant_at(1)), 64'd1);
    chk("s2_g2", 64'(grant_at(2)), 64'd2);
    chk("s2_g3", 64'(grant_at(3)), 64'd3);
    chk("s2_g4", 64'(grant_at(4)), 64'd0);
    drain();

    // Port 1 frame with toggling ready and a mid-frame link drop.
    dut_grants.delete();
    set_gen(4'b0010, 4);
    cyc();
    set_gen('0, 4);
    for (int i = 0; i < 12; i++) begin
      cyc();
      o_tready = (i % 2 == 0);
      if (i == 4) begin
        channel_up = 1'b0;
        set_gen(4'b1001, 1);
      end
    end
    o_tready = 1'b1;
    repeat (5) cyc();
    chk("s3_ngrants_down", 64'(dut_grants.size()), 64'd1);
    chk("s3_g0", 64'(grant_at(0)), 64'd1);
    channel_up = 1'b1;
    repeat (4) cyc();
    chk("s3_g1", 64'(grant_at(1)), 64'd3);
    drain();

    // Masked sources: only 1 and 3, then drop port 1 mid-frame.
    dut_grants.delete();
    port_en = 4'b1010;
    set_gen(4'b1111, 2);
    repeat (16) cyc();
    chk("s4_first", 64'(grant_at(0) == 1 || grant_at(0) == 3), 64'd1);
    for (int i = 1; i < 4; i++) chk("s4_alternate", 64'(grant_at(i) + grant_at(i - 1)), 64'd4);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (grant_vld && grant_idx == 2'd1) found = 1'b1;
      else cyc();
    end
    chk("s4_wait_port1", 64'(found), 64'd1);
    cyc();
    port_en = 4'b1000;
    n0 = dut_grants.size();
    repeat (15) cyc();
    chk("s4_more_grants", 64'(dut_grants.size() > n0), 64'd1);
    for (int i = n0; i < dut_grants.size(); i++) chk("s4_only3", 64'(dut_grants[i]), 64'd3);
    drain();

    // Back-to-back single-beat frames on ports 0 and 1.
    do_reset();
    dut_grants.delete();
    set_gen(4'b0011, 1);
    cyc();
    set_gen('0, 1);
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      pat = {pat[2:0], o_tvalid};
    end
    chk("s5_valid_pattern", 64'(pat), 64'b1010);
    chk("s5_g0", 64'(grant_at(0)), 64'd0);
    chk("s5_g1", 64'(grant_at(1)), 64'd1);
    drain();

    // Asynchronous reset during beat 2 of a 4-beat frame on port 3.
    set_gen(4'b1000, 4);
    cyc();
    set_gen('0, 4);
    cyc();
    cyc();
    @(negedge clk);
    chk("s6_in_frame", 64'(grant_vld && grant_idx == 2'd3), 64'd1);
    gen[0] = 1'b1; flen[0] = 2;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_rst_grant_vld", 64'(grant_vld), 64'd0);
    chk("s6_rst_o_tvalid", 64'(o_tvalid), 64'd0);
    chk("s6_rst_i_tready", 64'(i_tready), 64'd0);
    cyc();
    dut_grants.delete();
    rst = 1'b0;
    gen[0] = 1'b0;
    repeat (6) cyc();
    chk("s6_first_after_rst", 64'(grant_at(0)), 64'd0);
    drain();

    // Random traffic, stalls, link flaps and mask changes.
    set_gen(4'b1111, 0);
    rate = 40;
    stall_pct = 20;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      o_tready = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 5) channel_up = ~channel_up;
      if ($urandom_range(99) < 5) port_en = N'($urandom);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
